// File: rtl/node_pkg.sv
// Shared definitions for the ring node ingress path: port codes, packet field
// positions and the round-robin port-advance helper.
package node_pkg;

    localparam logic [1:0] PORT_RING0 = 2'b00;
    localparam logic [1:0] PORT_RING1 = 2'b01;
    localparam logic [1:0] PORT_LOCAL = 2'b10;

    localparam int DEST_MSB         = 31;
    localparam int ORIG_MSB         = 28;
    localparam int NODE_IP_BITWIDTH = 3;

    typedef logic [31:0] packet_t;

    // Next port in the 00 -> 01 -> 10 -> 00 rotation; code 11 is treated like 10
    function automatic logic [1:0] next_port(input logic [1:0] port);
        return (port >= PORT_LOCAL) ? PORT_RING0 : port + 2'd1;
    endfunction

endpackage

// File: rtl/node_input_fifo.sv
// Synchronous single-clock FIFO used once per ingress port. Full/empty are
// decoded from the registered occupancy count, so they never depend on a
// same-cycle push or pop.
module node_input_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage array is not reset; the emptied count makes old entries unreachable
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_input_arbiter.sv
// Ingress stage of a ring node: three per-port FIFOs feeding a round-robin
// arbiter with a registered output and a one-cycle controller_enable pulse.
// Optional macro RING_PRIORITY_EN: ring ports 00/01 share round-robin between
// themselves and the local port 10 is served only when both ring FIFOs are empty.
module node_input_arbiter
    import node_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in2_data,
    input  logic                  in2_valid,
    output logic                  in2_ready,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instruction_out,
    output logic [1:0]            source_port,
    output logic                  controller_enable
);

    logic [DATA_WIDTH-1:0] push_data [3];
    logic [DATA_WIDTH-1:0] head_data [3];
    logic [2:0]            valid_vec;
    logic [2:0]            full_vec;
    logic [2:0]            empty_vec;
    logic [2:0]            push_vec;
    logic [2:0]            pop_vec;
    logic [1:0]            last_grant;
    logic                  grant_valid;
    logic [1:0]            grant_port;
    logic [1:0]            cand;
    logic [DATA_WIDTH-1:0] grant_data;

    assign push_data[0] = in0_data;
    assign push_data[1] = in1_data;
    assign push_data[2] = in2_data;
    assign valid_vec    = {in2_valid, in1_valid, in0_valid};
    assign in0_ready    = !full_vec[0];
    assign in1_ready    = !full_vec[1];
    assign in2_ready    = !full_vec[2];
    assign push_vec     = valid_vec & ~full_vec;

    for (genvar p = 0; p < 3; p++) begin : g_fifo
        node_input_fifo #(
            .DEPTH (FIFO_DEPTH),
            .AW    (FIFO_AW),
            .WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_vec[p]),
            .push_data (push_data[p]),
            .pop       (pop_vec[p]),
            .head_data (head_data[p]),
            .full      (full_vec[p]),
            .empty     (empty_vec[p])
        );
    end

    // Search ports starting after last_grant; empty flags come from registered
    // counts, so a packet pushed this cycle cannot be granted until next cycle
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = PORT_RING0;
        cand        = last_grant;
        if (out_ready) begin
            for (int k = 0; k < 3; k++) begin
                cand = next_port(cand);
`ifdef RING_PRIORITY_EN
                if (!grant_valid && cand != PORT_LOCAL && !empty_vec[cand]) begin
`else
                if (!grant_valid && !empty_vec[cand]) begin
`endif
                    grant_valid = 1'b1;
                    grant_port  = cand;
                end
            end
`ifdef RING_PRIORITY_EN
            if (!grant_valid && !empty_vec[2]) begin
                grant_valid = 1'b1;
                grant_port  = PORT_LOCAL;
            end
`endif
        end
    end

    // Pop only the granted FIFO and steer its head to the output register
    always_comb begin
        pop_vec    = grant_valid ? (3'b001 << grant_port) : 3'b000;
        grant_data = head_data[0];
        case (grant_port)
            PORT_RING1: grant_data = head_data[1];
            PORT_LOCAL: grant_data = head_data[2];
            default:    grant_data = head_data[0];
        endcase
    end

    // Output register: outputs and pointer only move on a grant, enable pulses once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction_out   <= '0;
            source_port       <= PORT_RING0;
            controller_enable <= 1'b0;
            last_grant        <= PORT_LOCAL;
        end else begin
            controller_enable <= grant_valid;
            if (grant_valid) begin
                instruction_out <= grant_data;
                source_port     <= grant_port;
                last_grant      <= grant_port;
            end
        end
    end

endmodule

// File: tb/tb_node_input_arbiter.sv
// Scoreboard bench for node_input_arbiter: a queue-based reference model
// predicts each grant and pushes it to an expected queue; an independent
// monitor pops and compares whenever controller_enable is seen.
module tb_node_input_arbiter;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  port;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] in0_data, in1_data, in2_data;
    logic        in0_valid, in1_valid, in2_valid;
    logic        in0_ready, in1_ready, in2_ready;
    logic        out_ready;
    logic [31:0] instruction_out;
    logic [1:0]  source_port;
    logic        controller_enable;

    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [31:0] model_q [3][$];
    int          model_last = 2;
    exp_t        exp_q [$];
    logic [31:0] mon_last_data = '0;
    logic [1:0]  mon_last_port = '0;

    node_input_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .in0_data          (in0_data),
        .in0_valid         (in0_valid),
        .in0_ready         (in0_ready),
        .in1_data          (in1_data),
        .in1_valid         (in1_valid),
        .in1_ready         (in1_ready),
        .in2_data          (in2_data),
        .in2_valid         (in2_valid),
        .in2_ready         (in2_ready),
        .out_ready         (out_ready),
        .instruction_out   (instruction_out),
        .source_port       (source_port),
        .controller_enable (controller_enable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference choice: first non-empty port after the last grant (mod 3);
    // with ring priority, ring ports are searched first and local only as fallback
    function automatic int modelPick(input logic ordy);
        if (!ordy) return -1;
`ifdef RING_PRIORITY_EN
        for (int k = 1; k <= 3; k++) begin
            int p = (model_last + k) % 3;
            if (p != 2 && model_q[p].size() > 0) return p;
        end
        if (model_q[2].size() > 0) return 2;
`else
        for (int k = 1; k <= 3; k++) begin
            int p = (model_last + k) % 3;
            if (model_q[p].size() > 0) return p;
        end
`endif
        return -1;
    endfunction

    // One cycle of stimulus: drive inputs, check ready, advance the model
    task automatic applyStimulus(input logic v0, input logic v1, input logic v2,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic ordy);
        logic [2:0]  v;
        logic [31:0] d [3];
        int          g;
        bit          rdy [3];
        @(negedge clk);
        in0_valid = v0; in1_valid = v1; in2_valid = v2;
        in0_data  = d0; in1_data  = d1; in2_data  = d2;
        out_ready = ordy;
        v = {v2, v1, v0};
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int p = 0; p < 3; p++) rdy[p] = (model_q[p].size() < 4);
        #1;
        checkOutput("in0_ready", 32'(in0_ready), 32'(rdy[0]));
        checkOutput("in1_ready", 32'(in1_ready), 32'(rdy[1]));
        checkOutput("in2_ready", 32'(in2_ready), 32'(rdy[2]));
        g = modelPick(ordy);
        if (g >= 0) begin
            exp_t e;
            e.data = model_q[g].pop_front();
            e.port = 2'(g);
            exp_q.push_back(e);
            model_last = g;
        end
        for (int p = 0; p < 3; p++) begin
            if (v[p] && rdy[p]) model_q[p].push_back(d[p]);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, '0, '0, ordy);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear immediately
    task automatic doReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_instruction_out", instruction_out, 32'h0);
        checkOutput("rst_source_port", 32'(source_port), 32'h0);
        checkOutput("rst_enable", 32'(controller_enable), 32'h0);
        checkOutput("rst_in0_ready", 32'(in0_ready), 32'h1);
        for (int p = 0; p < 3; p++) model_q[p].delete();
        exp_q.delete();
        model_last    = 2;
        mon_last_data = '0;
        mon_last_port = '0;
        in0_valid = 0; in1_valid = 0; in2_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare every presented packet against the expected queue,
    // and confirm outputs hold when no packet is presented
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (controller_enable === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_enable", 32'h1, 32'h0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkOutput("instruction_out", instruction_out, e.data);
                        checkOutput("source_port", 32'(source_port), 32'(e.port));
                        mon_last_data = e.data;
                        mon_last_port = e.port;
                    end
                end else begin
                    checkOutput("enable_low", 32'(controller_enable), 32'h0);
                    checkOutput("hold_instruction_out", instruction_out, mon_last_data);
                    checkOutput("hold_source_port", 32'(source_port), 32'(mon_last_port));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in0_valid = 0; in1_valid = 0; in2_valid = 0;
        in0_data = '0; in1_data = '0; in2_data = '0;
        out_ready = 0;
        doReset();

        // Reset with packets queued on port 0: nothing must come out afterwards
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h0A00_0000 + 32'(i), '0, '0, 0);
        doReset();
        idle(4, 1);

        // Single local packet: two cycles valid-to-enable
        applyStimulus(0, 0, 1, '0, '0, 32'h6000_0001, 1);
        idle(4, 1);

        // Two packets on every port: fair rotation 00,01,10,00,01,10
        doReset();
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 1, 1, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
                          32'h3000_0000 + 32'(i), 0);
        idle(8, 1);

        // Fill port 1 while blocked; fifth packet refused, then drained in order
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, '0, 32'h4400_0000 + 32'(i), '0, 0);
        idle(6, 1);

        // out_ready 1,0,1 with backlog
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h5500_0000 + 32'(i), '0, '0, 0);
        applyStimulus(0, 0, 0, '0, '0, '0, 1);
        applyStimulus(0, 0, 0, '0, '0, '0, 0);
        applyStimulus(0, 0, 0, '0, '0, '0, 1);
        idle(4, 1);

        // Ports 0 and 2 loaded with two each
        doReset();
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 0, 1, 32'h0700_0000 + 32'(i), '0, 32'h0900_0000 + 32'(i), 0);
        idle(6, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                          ($urandom_range(0, 9) < 7));
        end
        idle(20, 1);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
